// File: rtl/deserializer.sv
// deserializer -- receive end of the bit-serial link.
//
// Collects bits qualified by ser_data_val_i into a left-aligned parallel word
// (first received bit lands in [DATA_W-1]). A frame closes when the valid
// strobe drops or when DATA_W bits have been collected. Gap-terminated frames
// shorter than MIN_LEN are discarded and flagged on drop_o.
//
// Ports:
//   clk_i            rising-edge clock
//   srst_i           asynchronous active-high reset
//   ser_data_i       serial bit, sampled when ser_data_val_i=1
//   ser_data_val_i   bit qualifier; contiguous high cycles form one frame
//   deser_data_o     last accepted word, left-aligned, unreceived bits 0
//   deser_data_mod_o length of that word in bits; 0 encodes DATA_W
//   deser_data_val_o one-cycle pulse: a new word is on deser_data_o
//   drop_o           one-cycle pulse: a short frame was discarded
//   busy_o           a frame is partially collected
//
// Handshake: deser_data_val_o is a valid-only strobe with no ready; the
// consumer must take deser_data_o/deser_data_mod_o in every cycle the strobe
// is high. The input side likewise has no backpressure.
module deserializer #(
  parameter int DATA_W  = 16,
  parameter int MIN_LEN = 3
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic                      ser_data_i,
  input  logic                      ser_data_val_i,
  output logic [DATA_W-1:0]         deser_data_o,
  output logic [$clog2(DATA_W)-1:0] deser_data_mod_o,
  output logic                      deser_data_val_o,
  output logic                      drop_o,
  output logic                      busy_o
);

  localparam int MW = $clog2(DATA_W);
  localparam int CW = MW + 1;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [MW-1:0]     mod_q, mod_d;
  logic              val_q, val_d;
  logic              drop_q, drop_d;

  // Shift register with the incoming bit placed at its slot; the slot index
  // counts down from the MSB as bits arrive.
  logic [DATA_W-1:0] sh_ins;
  logic [MW-1:0]     ins_idx;

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;
    drop_d  = 1'b0;
    ins_idx = MW'(DATA_W - 1) - cnt_q[MW-1:0];
    sh_ins  = sh_q;
    sh_ins[ins_idx] = ser_data_i;

    unique case (state_q)
      IDLE: begin
        if (ser_data_val_i) begin
          // sh is already clear in IDLE, so only the MSB needs writing.
          sh_d             = '0;
          sh_d[DATA_W-1]   = ser_data_i;
          cnt_d            = CW'(1);
          state_d          = COLLECT;
        end
      end
      COLLECT: begin
        if (ser_data_val_i) begin
          if (cnt_q == CW'(DATA_W - 1)) begin
            // Last slot filled: publish this edge so a following bit can
            // open the next frame with no lost cycle.
            data_d  = sh_ins;
            mod_d   = '0;
            val_d   = 1'b1;
            sh_d    = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            sh_d  = sh_ins;
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          if (cnt_q >= CW'(MIN_LEN)) begin
            data_d = sh_q;
            mod_d  = cnt_q[MW-1:0];
            val_d  = 1'b1;
          end else begin
            // Short frame: output word and length keep the last good frame.
            drop_d = 1'b1;
          end
          sh_d    = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        sh_d    = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign deser_data_o     = data_q;
  assign deser_data_mod_o = mod_q;
  assign deser_data_val_o = val_q;
  assign drop_o           = drop_q;
  assign busy_o           = (cnt_q != '0);

endmodule

// File: tb/tb_deserializer.sv
module tb_deserializer;

  localparam int DATA_W  = 16;
  localparam int MIN_LEN = 3;
  localparam int MW      = $clog2(DATA_W);
  // Scoreboard entry: {is_drop, mod, data, expected observation cycle}
  localparam int W       = 1 + MW + DATA_W + 32;

  logic              clk_i = 1'b0;
  logic              srst_i = 1'b1;
  logic              ser_data_i = 1'b0;
  logic              ser_data_val_i = 1'b0;
  logic [DATA_W-1:0] deser_data_o;
  logic [MW-1:0]     deser_data_mod_o;
  logic              deser_data_val_o;
  logic              drop_o;
  logic              busy_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] last_data = '0;
  logic [MW-1:0]     last_mod  = '0;

  deserializer #(.DATA_W(DATA_W), .MIN_LEN(MIN_LEN)) dut (
    .clk_i            (clk_i),
    .srst_i           (srst_i),
    .ser_data_i       (ser_data_i),
    .ser_data_val_i   (ser_data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_data_mod_o (deser_data_mod_o),
    .deser_data_val_o (deser_data_val_o),
    .drop_o           (drop_o),
    .busy_o           (busy_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks; inputs change on the falling edge, DUT samples on the rising
  task automatic send_bits(input logic [DATA_W-1:0] w, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk_i);
      ser_data_val_i = 1'b1;
      ser_data_i     = w[DATA_W-1-i];
    end
  endtask

  // Full-length frame: completes on the edge that samples the last bit.
  task automatic send_full(input logic [DATA_W-1:0] w);
    for (int i = 0; i < DATA_W; i++) begin
      @(negedge clk_i);
      chk("busy_full", 32'(busy_o), 32'(i != 0));
      ser_data_val_i = 1'b1;
      ser_data_i     = w[DATA_W-1-i];
      if (i == DATA_W - 1) begin
        exp_q.push_back({1'b0, MW'(0), w, 32'(cyc + 1)});
        last_data = w;
        last_mod  = '0;
      end
    end
  endtask

  // Drop valid after a partial frame of len bits whose word is w.
  task automatic end_gap(input logic [DATA_W-1:0] w, input int len);
    @(negedge clk_i);
    ser_data_val_i = 1'b0;
    ser_data_i     = 1'b0;
    if (len >= MIN_LEN) begin
      exp_q.push_back({1'b0, MW'(len), w, 32'(cyc + 1)});
      last_data = w;
      last_mod  = MW'(len);
    end else begin
      exp_q.push_back({1'b1, last_mod, last_data, 32'(cyc + 1)});
    end
  endtask

  // scoreboard: every pulse must match the head of the expected queue
  always @(negedge clk_i) begin
    logic [W-1:0] e;
    if (!srst_i && (deser_data_val_o || drop_o)) begin
      chk("val_drop_exclusive", 32'(deser_data_val_o & drop_o), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", 32'(drop_o), 32'(e[W-1]));
        chk("pulse_mod", 32'(deser_data_mod_o), 32'(e[W-2 -: MW]));
        chk("pulse_data", 32'(deser_data_o), 32'(e[W-2-MW -: DATA_W]));
        chk("pulse_cycle", 32'(cyc), e[31:0]);
      end
    end
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk_i);
    chk("rst_data", 32'(deser_data_o), 32'd0);
    chk("rst_mod", 32'(deser_data_mod_o), 32'd0);
    chk("rst_val", 32'(deser_data_val_o), 32'd0);
    chk("rst_drop", 32'(drop_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    srst_i = 1'b0;
    @(negedge clk_i);

    // 16-bit frame
    send_full(16'hA5C3);
    end_gap('0, 0);
    void'(exp_q.pop_back()); // valid drop from IDLE closes no frame
    @(negedge clk_i);
    chk("busy_after_full", 32'(busy_o), 32'd0);

    // 5-bit frame 1,0,1,1,0
    send_bits(16'hB000, 5);
    chk("busy_mid", 32'(busy_o), 32'd1);
    end_gap(16'hB000, 5);
    repeat (2) @(negedge clk_i);

    // short frame 1,1 -> dropped, previous word held
    send_bits(16'hC000, 2);
    end_gap(16'hC000, 2);
    repeat (2) @(negedge clk_i);
    chk("hold_data", 32'(deser_data_o), 32'h0000_B000);
    chk("hold_mod", 32'(deser_data_mod_o), 32'd5);

    // 32-bit burst: two full frames back to back
    send_full(16'hFFFF);
    send_full(16'h0001);
    @(negedge clk_i);
    ser_data_val_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // asynchronous reset after 7 bits
    send_bits(16'h5A00, 7);
    @(negedge clk_i);
    #2;
    srst_i         = 1'b1;
    ser_data_val_i = 1'b0;
    #1;
    chk("arst_data", 32'(deser_data_o), 32'd0);
    chk("arst_mod", 32'(deser_data_mod_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    last_data = '0;
    last_mod  = '0;
    @(negedge clk_i);
    srst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("post_rst_busy", 32'(busy_o), 32'd0);
    send_bits(16'hA000, 3);
    end_gap(16'hA000, 3);
    repeat (2) @(negedge clk_i);

    // MIN_LEN edge: 2 bits, one-cycle gap, 3 bits
    send_bits(16'h4000, 2);
    end_gap(16'h4000, 2);
    send_bits(16'hC000, 3);
    end_gap(16'hC000, 3);

    // random-length frames
    for (int n = 0; n < 6; n++) begin
      int len;
      logic [DATA_W-1:0] w;
      len = $urandom_range(1, DATA_W - 1);
      w   = DATA_W'($urandom);
      w   = w & ~({DATA_W{1'b1}} >> len);
      send_bits(w, len);
      end_gap(w, len);
    end

    // drain, bounded
    repeat (4) @(negedge clk_i);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
